// File: rtl/myproject_mul_share_pkg.sv
// Shared definitions for the myproject shared-multiplier scheduler:
// default widths, tag width helper and the tagged response record.
package myproject_mul_share_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int DIN0_WIDTH_DEF = 11;
    localparam int DIN1_WIDTH_DEF = 10;
    localparam int DOUT_WIDTH_DEF = 20;

    // Width of a requester tag; a single requester still needs one bit.
    function automatic int id_width(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

    localparam int ID_WIDTH_DEF = id_width(NUM_REQ_DEF);

    // One delivered product together with the requester that issued it.
    typedef struct packed {
        logic [DOUT_WIDTH_DEF-1:0] dout;
        logic [ID_WIDTH_DEF-1:0]   id;
    } mul_rsp_t;

endpackage

// File: rtl/myproject_mul_share_arb_if.sv
// Request/response bundle between the lane sequencers, the shared
// multiplier scheduler and the downstream consumer.
interface myproject_mul_share_arb_if
    import myproject_mul_share_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DIN0_WIDTH = DIN0_WIDTH_DEF,
    parameter int DIN1_WIDTH = DIN1_WIDTH_DEF,
    parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
    parameter int ID_WIDTH   = id_width(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
    logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [DOUT_WIDTH-1:0]         rsp_dout;
    logic [ID_WIDTH-1:0]           rsp_id;

    // Requesters and the downstream consumer.
    modport master (
        output req_valid, req_din0, req_din1, rsp_ready,
        input  req_ready, rsp_valid, rsp_dout, rsp_id
    );

    // The scheduler itself.
    modport slave (
        input  req_valid, req_din0, req_din1, rsp_ready,
        output req_ready, rsp_valid, rsp_dout, rsp_id
    );

endinterface

// File: rtl/myproject_mul_share_core.sv
// Purely combinational unsigned multiplier shared by all requesters.
// The product is formed at full operand width and only the low
// DOUT_WIDTH bits are kept (no saturation).
module myproject_mul_share_core
    import myproject_mul_share_pkg::*;
#(
    parameter int DIN0_WIDTH = DIN0_WIDTH_DEF,
    parameter int DIN1_WIDTH = DIN1_WIDTH_DEF,
    parameter int DOUT_WIDTH = DOUT_WIDTH_DEF
) (
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic [DOUT_WIDTH-1:0] dout
);

    localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

    // Zero-extend both operands to the full product width, then keep the low bits.
    assign dout = DOUT_WIDTH'(PROD_WIDTH'(din0) * PROD_WIDTH'(din1));

endmodule

// File: rtl/myproject_mul_share_arb.sv
// Round-robin scheduler time-sharing one multiplier among NUM_REQ
// requesters. One grant per cycle, registered tagged product out.
// Optional feature macro: MUL_SHARE_OUT_REG_EN adds a second output
// register stage (latency 2 instead of 1, still one product per cycle).
module myproject_mul_share_arb
    import myproject_mul_share_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DIN0_WIDTH = DIN0_WIDTH_DEF,
    parameter int DIN1_WIDTH = DIN1_WIDTH_DEF,
    parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
    parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    myproject_mul_share_arb_if.slave  bus,
    output logic                      busy,
    output logic [15:0]               op_count
);

    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   win;
    logic [ID_WIDTH-1:0]   cand;
    logic                  found;
    logic                  free;
    logic                  accept;
    logic [DIN0_WIDTH-1:0] sel_din0;
    logic [DIN1_WIDTH-1:0] sel_din1;
    logic [DOUT_WIDTH-1:0] prod;

    logic                  s1_valid;
    logic [DOUT_WIDTH-1:0] s1_dout;
    logic [ID_WIDTH-1:0]   s1_id;

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Only the winner sees ready, and only when the first stage can take a result.
    always_comb begin
        bus.req_ready = '0;
        if (found) begin
            bus.req_ready[win] = free;
        end
    end

    assign accept   = found && free;
    assign sel_din0 = bus.req_din0[int'(win)*DIN0_WIDTH +: DIN0_WIDTH];
    assign sel_din1 = bus.req_din1[int'(win)*DIN1_WIDTH +: DIN1_WIDTH];

    myproject_mul_share_core #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .DOUT_WIDTH (DOUT_WIDTH)
    ) u_core (
        .din0 (sel_din0),
        .din1 (sel_din1),
        .dout (prod)
    );

    // Pointer moves past the winner on accept so every requester gets its turn.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        end
    end

    // Count accepted operations; wraps naturally at 16 bits.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            op_count <= '0;
        end else if (accept) begin
            op_count <= op_count + 16'd1;
        end
    end

    // Product register: refilled (or emptied) whenever it is free to move.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s1_valid <= 1'b0;
            s1_dout  <= '0;
            s1_id    <= '0;
        end else if (free) begin
            s1_valid <= accept;
            if (accept) begin
                s1_dout <= prod;
                s1_id   <= win;
            end
        end
    end

`ifdef MUL_SHARE_OUT_REG_EN
    logic                  s2_valid;
    logic [DOUT_WIDTH-1:0] s2_dout;
    logic [ID_WIDTH-1:0]   s2_id;
    logic                  s2_free;

    assign s2_free = !s2_valid || bus.rsp_ready;
    assign free    = !s1_valid || s2_free;

    // Output register: takes stage 1 whenever it is empty or being drained.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            s2_valid <= 1'b0;
            s2_dout  <= '0;
            s2_id    <= '0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_dout <= s1_dout;
                s2_id   <= s1_id;
            end
        end
    end

    assign bus.rsp_valid = s2_valid;
    assign bus.rsp_dout  = s2_dout;
    assign bus.rsp_id    = s2_id;
    assign busy          = s1_valid || s2_valid;
`else
    assign free          = !s1_valid || bus.rsp_ready;
    assign bus.rsp_valid = s1_valid;
    assign bus.rsp_dout  = s1_dout;
    assign bus.rsp_id    = s1_id;
    assign busy          = s1_valid;
`endif

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Self-checking bench for myproject_mul_share_arb. Stimulus pushes the
// hand-computed tagged product into a scoreboard at each expected grant;
// a monitor pops and compares at every response handshake.
// Honours MUL_SHARE_OUT_REG_EN (expected latency 2 instead of 1).
module tb_myproject_mul_share_arb;
    import myproject_mul_share_pkg::*;

    localparam int NR = 4;
    localparam int W0 = 11;
    localparam int W1 = 10;
    localparam int WD = 20;
    localparam int WI = 2;
`ifdef MUL_SHARE_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        busy;
    logic [15:0] op_count;
    int          total = 0;
    int          bad = 0;
    int          exp_ops = 0;
    mul_rsp_t    sb[$];

    myproject_mul_share_arb_if #(
        .NUM_REQ (NR), .DIN0_WIDTH (W0), .DIN1_WIDTH (W1),
        .DOUT_WIDTH (WD), .ID_WIDTH (WI)
    ) bus ();

    myproject_mul_share_arb #(
        .NUM_REQ (NR), .DIN0_WIDTH (W0), .DIN1_WIDTH (W1),
        .DOUT_WIDTH (WD), .ID_WIDTH (WI)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    // Free-running clock, period 10.
    always #5 ap_clk = ~ap_clk;

    // Hard time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic mul_rsp_t mk(input int unsigned d, input int unsigned id);
        mul_rsp_t r;
        r.dout = WD'(d);
        r.id   = WI'(id);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setReq(input int i, input logic [W0-1:0] a, input logic [W1-1:0] b);
        bus.req_valid[i]         = 1'b1;
        bus.req_din0[i*W0 +: W0] = a;
        bus.req_din1[i*W1 +: W1] = b;
    endtask

    // One cycle: check the grant mask, record the expected product if granted.
    task automatic applyStimulus(input logic [NR-1:0] exp_ready, input logic do_push, input mul_rsp_t exp);
        @(negedge ap_clk);
        checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        if (do_push) begin
            sb.push_back(exp);
            exp_ops++;
        end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        bus.req_valid = '0;
        for (int c = 0; c < n; c++) begin
            applyStimulus('0, 1'b0, mk(0, 0));
        end
    endtask

    // Monitor: every response handshake must match the oldest expectation.
    always @(negedge ap_clk) begin
        if (!ap_rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rsp", 32'(bus.rsp_valid), 32'(0));
            end else begin
                mul_rsp_t e;
                e = sb.pop_front();
                checkOutput("rsp_dout", 32'(bus.rsp_dout), 32'(e.dout));
                checkOutput("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            end
        end
    end

    initial begin
        int cnt;
        int start;
        int idx;
        int prods[4];
        prods = '{10, 40, 90, 160};

        bus.req_valid = '0;
        bus.req_din0  = '0;
        bus.req_din1  = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        checkOutput("rst_rsp_dout", 32'(bus.rsp_dout), 32'(0));
        checkOutput("rst_op_count", 32'(op_count), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;

        // All four requesters, 3*5: grants 0,1,2,3,0.
        for (int i = 0; i < NR; i++) setReq(i, 11'd3, 10'd5);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'(1 << (k % 4)), 1'b1, mk(15, k % 4));
        end
        idleCycles(LAT + 1);
        checkOutput("op_count_5", 32'(op_count), 32'(5));
        checkOutput("busy_idle", 32'(busy), 32'(0));

        // Requester 2 alone, truncated product, latency measurement.
        setReq(2, 11'd2047, 10'd1023);
        applyStimulus(4'b0100, 1'b1, mk(32'hFF401, 2));
        bus.req_valid = '0;
        cnt = 1;
        @(negedge ap_clk);
        while (!bus.rsp_valid && cnt < 8) begin
            @(negedge ap_clk);
            cnt++;
        end
        checkOutput("latency", 32'(cnt), 32'(LAT));
        checkOutput("trunc_id", 32'(bus.rsp_id), 32'(2));
        @(posedge ap_clk);
        #1;
        idleCycles(LAT + 1);

        // Back-pressure: pointer is at 3, so requester 3 wins first.
        for (int i = 0; i < NR; i++) setReq(i, 11'(i + 1), 10'(10 * (i + 1)));
        applyStimulus(4'b1000, 1'b1, mk(160, 3));
        bus.rsp_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
`ifdef MUL_SHARE_OUT_REG_EN
            if (s == 0) applyStimulus(4'b0001, 1'b1, mk(10, 0));
            else        applyStimulus('0, 1'b0, mk(0, 0));
`else
            applyStimulus('0, 1'b0, mk(0, 0));
`endif
            if (s >= 1) begin
                checkOutput("stall_valid", 32'(bus.rsp_valid), 32'(1));
                checkOutput("stall_dout", 32'(bus.rsp_dout), 32'(160));
                checkOutput("stall_id", 32'(bus.rsp_id), 32'(3));
            end
        end
        bus.rsp_ready = 1'b1;
        start = LAT - 1;
        for (int k = 0; k < 4; k++) begin
            idx = (start + k) % 4;
            applyStimulus(4'(1 << idx), 1'b1, mk(prods[idx], idx));
        end
        idleCycles(LAT + 2);
        checkOutput("sb_empty_bp", 32'(sb.size()), 32'(0));
        checkOutput("op_count_bp", 32'(op_count), 32'(exp_ops));

        // Reset while a result is held: it must vanish and ptr return to 0.
        bus.rsp_ready = 1'b0;
        setReq(1, 11'd7, 10'd9);
        applyStimulus(4'b0010, 1'b0, mk(0, 0));
        bus.req_valid = '0;
        cnt = 0;
        @(negedge ap_clk);
        while (!bus.rsp_valid && cnt < 8) begin
            @(negedge ap_clk);
            cnt++;
        end
        checkOutput("pre_rst_valid", 32'(bus.rsp_valid), 32'(1));
        ap_rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 32'(bus.rsp_valid), 32'(0));
        checkOutput("async_rst_count", 32'(op_count), 32'(0));
        checkOutput("async_rst_busy", 32'(busy), 32'(0));
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        exp_ops = 0;
        bus.rsp_ready = 1'b1;
        setReq(3, 11'd4, 10'd4);
        setReq(1, 11'd7, 10'd9);
        applyStimulus(4'b0010, 1'b1, mk(63, 1));
        applyStimulus(4'b1000, 1'b1, mk(16, 3));
        idleCycles(LAT + 1);
        checkOutput("op_count_after_rst", 32'(op_count), 32'(2));

        // Counter wrap: 65536 accepts from a clean reset.
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        exp_ops = 0;
        for (int k = 0; k < 65536; k++) begin
            if (k == 65535) checkOutput("op_count_ffff", 32'(op_count), 32'hFFFF);
            setReq(0, 11'(k), 10'd3);
            applyStimulus(4'b0001, 1'b1, mk((k % 2048) * 3, 0));
        end
        checkOutput("op_count_wrap", 32'(op_count), 32'(0));
        idleCycles(LAT + 2);
        checkOutput("sb_empty_end", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
